// File: rtl/alu_controller.sv
// alu_controller: sequential front end for a combinational signed ALU.
// Accepts 8-bit instruction words over a valid/ready handshake, keeps a
// 4-entry register file, drives the ALU operands and mode for one EXEC
// cycle, then writes the ALU result back and updates the status flags.
// A MOVI instruction uses the next accepted word as a verbatim immediate.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   instr_valid/ready/data  instruction handshake (data is 8 bits)
//   alu_first, alu_second   registered ALU operands A and B
//   alu_mul, alu_sub        registered ALU mode, high only during EXEC
//   alu_result              combinational ALU result
//   wb_valid/addr/data      one-cycle write-back report
//   flag_z, flag_n, flag_v  status of the last written value
//   dbg_sel, dbg_data       combinational register-file read port
module alu_controller #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [7:0]       instr_data,
    output logic [WIDTH-1:0] alu_first,
    output logic [WIDTH-1:0] alu_second,
    output logic             alu_mul,
    output logic             alu_sub,
    input  logic [WIDTH-1:0] alu_result,
    output logic             wb_valid,
    output logic [1:0]       wb_addr,
    output logic [WIDTH-1:0] wb_data,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    input  logic [1:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {StIdle, StExec, StImm} state_e;

    localparam logic [1:0] OpAdd  = 2'b00;
    localparam logic [1:0] OpSub  = 2'b01;
    localparam logic [1:0] OpMul  = 2'b10;
    localparam logic [1:0] OpMovi = 2'b11;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rf_q [4];
    logic [WIDTH-1:0] rf_d [4];
    logic [WIDTH-1:0] alu_first_q, alu_first_d;
    logic [WIDTH-1:0] alu_second_q, alu_second_d;
    logic             alu_mul_q, alu_mul_d;
    logic             alu_sub_q, alu_sub_d;
    logic [1:0]       rd_q, rd_d;
    logic             wb_valid_q, wb_valid_d;
    logic [1:0]       wb_addr_q, wb_addr_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_n_q, flag_n_d;
    logic             flag_v_q, flag_v_d;

    logic       accept;
    logic [1:0] opcode;
    logic       a_sign, b_sign, r_sign;

    assign instr_ready = (state_q != StExec);
    assign accept      = instr_valid && instr_ready;
    assign opcode      = instr_data[7:6];

    // Operand signs come from the registered operands, which still hold the
    // values the ALU is working on during EXEC.
    assign a_sign = alu_first_q[WIDTH-1];
    assign b_sign = alu_second_q[WIDTH-1];
    assign r_sign = alu_result[WIDTH-1];

    always_comb begin
        state_d      = state_q;
        rf_d         = rf_q;
        alu_first_d  = alu_first_q;
        alu_second_d = alu_second_q;
        alu_mul_d    = alu_mul_q;
        alu_sub_d    = alu_sub_q;
        rd_d         = rd_q;
        wb_valid_d   = 1'b0;
        wb_addr_d    = wb_addr_q;
        wb_data_d    = wb_data_q;
        flag_z_d     = flag_z_q;
        flag_n_d     = flag_n_q;
        flag_v_d     = flag_v_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    rd_d = instr_data[5:4];
                    if (opcode == OpMovi) begin
                        state_d = StImm;
                    end else begin
                        alu_first_d  = rf_q[instr_data[3:2]];
                        alu_second_d = rf_q[instr_data[1:0]];
                        alu_mul_d    = (opcode == OpMul);
                        alu_sub_d    = (opcode == OpSub);
                        state_d      = StExec;
                    end
                end
            end
            StExec: begin
                rf_d[rd_q] = alu_result;
                wb_valid_d = 1'b1;
                wb_addr_d  = rd_q;
                wb_data_d  = alu_result;
                flag_z_d   = (alu_result == '0);
                flag_n_d   = r_sign;
                if (alu_mul_q) begin
                    flag_v_d = 1'b0;
                end else if (alu_sub_q) begin
                    flag_v_d = (a_sign != b_sign) && (r_sign != a_sign);
                end else begin
                    flag_v_d = (a_sign == b_sign) && (r_sign != a_sign);
                end
                alu_mul_d = 1'b0;
                alu_sub_d = 1'b0;
                state_d   = StIdle;
            end
            StImm: begin
                // The immediate word is stored verbatim, never decoded.
                if (accept) begin
                    rf_d[rd_q] = WIDTH'(instr_data);
                    wb_valid_d = 1'b1;
                    wb_addr_d  = rd_q;
                    wb_data_d  = WIDTH'(instr_data);
                    flag_z_d   = (WIDTH'(instr_data) == '0);
                    flag_n_d   = instr_data[7];
                    flag_v_d   = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            for (int i = 0; i < 4; i++) rf_q[i] <= '0;
            alu_first_q  <= '0;
            alu_second_q <= '0;
            alu_mul_q    <= 1'b0;
            alu_sub_q    <= 1'b0;
            rd_q         <= '0;
            wb_valid_q   <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            flag_z_q     <= 1'b0;
            flag_n_q     <= 1'b0;
            flag_v_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            for (int i = 0; i < 4; i++) rf_q[i] <= rf_d[i];
            alu_first_q  <= alu_first_d;
            alu_second_q <= alu_second_d;
            alu_mul_q    <= alu_mul_d;
            alu_sub_q    <= alu_sub_d;
            rd_q         <= rd_d;
            wb_valid_q   <= wb_valid_d;
            wb_addr_q    <= wb_addr_d;
            wb_data_q    <= wb_data_d;
            flag_z_q     <= flag_z_d;
            flag_n_q     <= flag_n_d;
            flag_v_q     <= flag_v_d;
        end
    end

    assign alu_first  = alu_first_q;
    assign alu_second = alu_second_q;
    assign alu_mul    = alu_mul_q;
    assign alu_sub    = alu_sub_q;
    assign wb_valid   = wb_valid_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign flag_z     = flag_z_q;
    assign flag_n     = flag_n_q;
    assign flag_v     = flag_v_q;
    assign dbg_data   = rf_q[dbg_sel];

endmodule

// File: tb/tb_alu_controller.sv
// tb_alu_controller: scoreboard bench for alu_controller. The driver feeds
// words through a reference model that predicts every write-back; a monitor
// pops and compares each time wb_valid is seen. The ALU itself is modelled
// here as plain combinational arithmetic.
module tb_alu_controller;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_data;
    logic [7:0] alu_first;
    logic [7:0] alu_second;
    logic       alu_mul;
    logic       alu_sub;
    logic [7:0] alu_result;
    logic       wb_valid;
    logic [1:0] wb_addr;
    logic [7:0] wb_data;
    logic       flag_z;
    logic       flag_n;
    logic       flag_v;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;

    alu_controller #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_data (instr_data),
        .alu_first  (alu_first),
        .alu_second (alu_second),
        .alu_mul    (alu_mul),
        .alu_sub    (alu_sub),
        .alu_result (alu_result),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .flag_v     (flag_v),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    // Combinational ALU; 8-bit context truncates the product.
    always_comb begin
        if (alu_mul)      alu_result = alu_first * alu_second;
        else if (alu_sub) alu_result = alu_first - alu_second;
        else              alu_result = alu_first + alu_second;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] data;
        logic       z;
        logic       n;
        logic       v;
    } wb_t;

    wb_t        exp_q[$];
    logic [7:0] m_rf [4];
    logic       imm_pending;
    logic [1:0] imm_rd;
    int         n_checks;
    int         n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        imm_pending = 1'b0;
        imm_rd      = 2'd0;
        exp_q.delete();
    endtask

    // Predicts the architectural effect of one accepted word.
    task automatic model_accept(input logic [7:0] w);
        wb_t e;
        int  a, b, r;
        if (imm_pending) begin
            m_rf[imm_rd] = w;
            e.addr = imm_rd; e.data = w; e.z = (w == 8'h00); e.n = w[7]; e.v = 1'b0;
            exp_q.push_back(e);
            imm_pending = 1'b0;
        end else if (w[7:6] == 2'b11) begin
            imm_pending = 1'b1;
            imm_rd      = w[5:4];
        end else begin
            a = int'($signed(m_rf[w[3:2]]));
            b = int'($signed(m_rf[w[1:0]]));
            case (w[7:6])
                2'b00:   r = a + b;
                2'b01:   r = a - b;
                default: r = a * b;
            endcase
            e.addr = w[5:4];
            e.data = r[7:0];
            e.z    = (r[7:0] == 8'h00);
            e.n    = r[7];
            e.v    = (w[7:6] != 2'b10) && (r > 127 || r < -128);
            m_rf[w[5:4]] = e.data;
            exp_q.push_back(e);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    // with instr_valid still high. Data is scrambled while not ready.
    task automatic send(input logic [7:0] w, output int waits);
        waits = 0;
        instr_valid = 1'b1;
        forever begin
            if (instr_ready) begin
                instr_data = w;
                model_accept(w);
                @(negedge clk);
                break;
            end
            instr_data = 8'($urandom);
            waits++;
            if (waits > 10) begin
                check("accept_timeout", 32'(waits), 32'd0);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        instr_valid = 1'b0;
        instr_data  = 8'($urandom);
        repeat (n) @(negedge clk);
    endtask

    task automatic movi(input logic [1:0] rd, input logic [7:0] val);
        int w;
        send({2'b11, rd, 4'b0000}, w);
        send(val, w);
        check("movi_imm_back_to_back", 32'(w), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_alu_first"}, 32'(alu_first), 32'd0);
        check({tag, "_alu_second"}, 32'(alu_second), 32'd0);
        check({tag, "_alu_mode"}, {30'd0, alu_mul, alu_sub}, 32'd0);
        check({tag, "_wb"}, {21'd0, wb_valid, wb_addr, wb_data}, 32'd0);
        check({tag, "_flags"}, {29'd0, flag_z, flag_n, flag_v}, 32'd0);
    endtask

    task automatic sweep_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            check({tag, "_dbg_reg"}, {22'd0, dbg_sel, dbg_data}, {22'd0, dbg_sel, m_rf[i]});
        end
    endtask

    // Monitor: compares each write-back against the oldest prediction.
    logic prev_wb;
    initial begin
        wb_t e;
        prev_wb = 1'b0;
        forever begin
            @(negedge clk);
            if (wb_valid) begin
                check("wb_not_back_to_back", 32'(prev_wb), 32'd0);
                check("wb_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wb_addr", 32'(wb_addr), 32'(e.addr));
                    check("wb_data", 32'(wb_data), 32'(e.data));
                    check("flags_znv", {29'd0, flag_z, flag_n, flag_v}, {29'd0, e.z, e.n, e.v});
                end
            end
            if (alu_mul || alu_sub) check("alu_mode_only_in_exec", 32'(instr_ready), 32'd0);
            prev_wb = wb_valid;
        end
    end

    initial begin
        int w;
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_data  = 8'h00;
        dbg_sel     = 2'd0;
        model_reset();

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", 32'(instr_ready), 32'd1);
        sweep_regs("reset");
        @(negedge clk);

        // Basic add.
        movi(2'd0, 8'h05);
        movi(2'd1, 8'h03);
        send(8'h21, w);
        idle(3);

        // Signed overflow, then self-subtract to zero.
        movi(2'd0, 8'h7F);
        movi(2'd1, 8'h01);
        send(8'h31, w);
        send(8'h70, w);
        idle(3);

        // Signed multiply and truncation.
        movi(2'd0, 8'hFD);
        movi(2'd1, 8'h04);
        send(8'hA1, w);
        movi(2'd0, 8'h10);
        send(8'hA0, w);
        idle(3);

        // Aliasing and immediate dependent use.
        movi(2'd1, 8'h06);
        send(8'h55, w);
        send(8'h65, w);
        check("dependent_accept_first_ready", 32'(w), 32'd1);
        idle(3);

        // Continuous valid: each op after the first waits exactly one cycle.
        movi(2'd0, 8'h3C);
        movi(2'd1, 8'hC5);
        send(8'h21, w);
        send(8'h32, w);
        check("stream_op2_wait", 32'(w), 32'd1);
        send(8'h4B, w);
        check("stream_op3_wait", 32'(w), 32'd1);
        send(8'hAE, w);
        check("stream_op4_wait", 32'(w), 32'd1);
        idle(4);
        sweep_regs("stream");

        // Reset during EXEC aborts the write.
        movi(2'd0, 8'h11);
        movi(2'd1, 8'h22);
        send(8'h21, w);
        instr_valid = 1'b0;
        rst_n       = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("rst_exec");
        sweep_regs("rst_exec");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst_exec", 32'(instr_ready), 32'd1);
        @(negedge clk);
        idle(2);

        // Reset during IMM; the would-be immediate is then an ADD.
        movi(2'd0, 8'h09);
        send(8'hE0, w);
        instr_valid = 1'b0;
        rst_n       = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("rst_imm");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst_imm", 32'(instr_ready), 32'd1);
        @(negedge clk);
        send(8'h21, w);
        idle(3);
        sweep_regs("rst_imm");

        // Random traffic with random gaps.
        for (int i = 0; i < 200; i++) begin
            send(8'($urandom), w);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        if (imm_pending) send(8'($urandom), w);
        idle(5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        sweep_regs("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
